shift_reg_scheduler: RTL and testbench
======================================

// Module: shift_reg_scheduler
//
// PURPOSE
// - Shares one serial-in shift register (ports clock/enable/data_in, out[WIDTH-1:0]) between two requesters.
// - Each requester offers a parallel WIDTH-bit word.
// - The block arbitrates round-robin, serialises the granted word LSB-first onto sr_data/sr_enable, then pulses done.
// - It sits between the producers and the shift-register datapath.
// - It is the only driver of that register's enable and data_in.
//
// PARAMETERS
// - WIDTH  default 4  word width; equals the width of the driven shift register's out.
// - CNT_W  default 2  bit-counter width; must satisfy 2**CNT_W >= WIDTH.
//
// PORTS
// - clock      in   1      rising-edge clock
// - reset_n    in   1      synchronous, active-low reset
// - req        in   2      req[i]=1: requester i has a word pending; held high until grant[i]
// - word0      in   WIDTH  requester 0 word; sampled at the accept edge only
// - word1      in   WIDTH  requester 1 word; sampled at the accept edge only
// - grant      out  2      one-hot, one-cycle pulse in the first shift cycle of the granted job
// - sr_enable  out  1      drives the shift register's enable
// - sr_data    out  1      drives the shift register's data_in
// - busy       out  1      high while a job is shifting
// - done       out  1      one-cycle pulse after the last bit of a job
// - done_id    out  1      requester index of the finished job; valid while done=1
//
// BEHAVIOUR
// - All outputs are registered.
// - Reset (reset_n=0 at an edge), valid in any state including mid-job:
//   - state=IDLE, cnt=0.
//   - grant=0, sr_enable=0, sr_data=0, busy=0, done=0, done_id=0.
//   - last=1, so requester 0 wins the first tie.
//   - A partially shifted word is abandoned; no done pulse is issued.
// - FSM states are IDLE, SHIFT and DONE.
// - IDLE/DONE -> SHIFT at an edge where req!=0 (the accept edge):
//   - Winner: if only one req bit is set, that requester; if both are set, the requester != last.
//   - At the accept edge: latch the winner's word into shreg, set last=winner, cnt=0.
//   - Registered outputs after the accept edge: grant[winner]=1, sr_enable=1, sr_data=word[0], busy=1.
// - SHIFT, cycles k=1..WIDTH after the accept edge:
//   - sr_enable=1, sr_data=word[k-1] (LSB first), busy=1.
//   - grant is high only in cycle 1.
//   - After WIDTH enabled edges, the downstream out equals the word (MSB-insertion register).
// - SHIFT -> DONE after cycle WIDTH:
//   - In cycle WIDTH+1: sr_enable=0, sr_data=0, busy=0, done=1, done_id=last.
// - DONE arbitrates exactly like IDLE, so a pending req is accepted at the end of the DONE cycle.
//   - Back-to-back throughput is one job per WIDTH+1 cycles.
//   - With no req, DONE -> IDLE.
// - req changes during SHIFT are ignored.
//   - A requester that drops req before grant is never served (no sticky request).
// - req=2'b00 in IDLE: stay in IDLE, all outputs 0.
// - cnt counts 0..WIDTH-1 and does not wrap inside a job.
// - sr_enable is never high outside SHIFT.
//
// CONFIGURATION
// - Macro SRS_ABORT_EN.
// - Defined:
//   - Adds input abort (1 bit).
//   - abort=1 at an edge in SHIFT: next cycle sr_enable=0, busy=0, done=0, and a 1-cycle pulse on the extra output aborted; state=IDLE.
//   - last keeps the aborted requester.
//   - abort is ignored in IDLE and DONE.
// - Undefined: no abort or aborted ports; every accepted job runs to done.
//
// TESTING
// - Reset, then req=01, word0=4'b1011 -> grant=01 one cycle; sr_data=1,1,0,1 with sr_enable=1 for 4 cycles; then done=1, done_id=0; downstream out=4'b1011.
// - req=11 held, word0=4'h3, word1=4'hC -> job0 (id 0) then job1 (id 1) back-to-back; second grant 5 cycles after the first; done pulses 5 cycles apart.
// - Keep req=11 for four jobs -> grant sequence 0,1,0,1; sr_enable never high in any DONE cycle.
// - reset_n=0 in SHIFT cycle 2 -> next cycle all outputs 0; no done; next req=10 is granted to requester 1.
// - req=00 for 10 cycles after reset -> sr_enable, busy, grant and done all stay 0.
// - [SRS_ABORT_EN] abort=1 in SHIFT cycle 2 -> aborted=1 and sr_enable=0 next cycle; done never asserts; next req=01 starts normally.

Source files
------------

// File: rtl/shift_reg_scheduler.sv
// Round-robin arbiter that serialises one of two parallel words LSB-first into a shared shift register.
// Optional abort support is compiled in with `define SRS_ABORT_EN (adds ports abort / aborted).
module shift_reg_scheduler #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] word0,
  input  logic [WIDTH-1:0] word1,
`ifdef SRS_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [1:0]       grant,
  output logic             sr_enable,
  output logic             sr_data,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [1:0]       state_dbg
);

  // Handshake: req[i] is a level held by requester i until it observes grant[i];
  // the word is captured on the accept edge, so it only needs to be stable there.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             last, last_nxt;
  logic [1:0]       grant_nxt;
  logic             sr_enable_nxt;
  logic             sr_data_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             done_id_nxt;
`ifdef SRS_ABORT_EN
  logic             aborted_nxt;
`endif

  logic             winner;
  logic [WIDTH-1:0] win_word;

  // On a tie the requester that was not served last wins.
  assign winner   = req[1] & (~req[0] | ~last);
  assign win_word = winner ? word1 : word0;

  assign state_dbg = state;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    shreg_nxt     = shreg;
    last_nxt      = last;
    grant_nxt     = 2'b00;
    sr_enable_nxt = 1'b0;
    sr_data_nxt   = 1'b0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    done_id_nxt   = done_id;
`ifdef SRS_ABORT_EN
    aborted_nxt   = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        if (req != 2'b00) begin
          state_nxt     = SHIFT;
          cnt_nxt       = '0;
          shreg_nxt     = win_word;
          last_nxt      = winner;
          grant_nxt     = winner ? 2'b10 : 2'b01;
          sr_enable_nxt = 1'b1;
          sr_data_nxt   = win_word[0];
          busy_nxt      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
`ifdef SRS_ABORT_EN
        if (abort) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          aborted_nxt = 1'b1;
        end else
`endif
        if (cnt == CNT_LAST) begin
          state_nxt   = DONE;
          done_nxt    = 1'b1;
          done_id_nxt = last;
        end else begin
          // shreg[0] is always the bit currently on sr_data.
          cnt_nxt       = cnt + 1'b1;
          shreg_nxt     = shreg >> 1;
          sr_enable_nxt = 1'b1;
          sr_data_nxt   = shreg_nxt[0];
          busy_nxt      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      last      <= 1'b1;
      grant     <= 2'b00;
      sr_enable <= 1'b0;
      sr_data   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= 1'b0;
`ifdef SRS_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      shreg     <= shreg_nxt;
      last      <= last_nxt;
      grant     <= grant_nxt;
      sr_enable <= sr_enable_nxt;
      sr_data   <= sr_data_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      done_id   <= done_id_nxt;
`ifdef SRS_ABORT_EN
      aborted   <= aborted_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_shift_reg_scheduler.sv
// Bench for shift_reg_scheduler: job-timeline reference model, per-cycle compare, directed and random phases.
// Abort scenarios are included when SRS_ABORT_EN is defined.
module tb_shift_reg_scheduler;
  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       req     = 2'b00;
  logic [WIDTH-1:0] word0   = '0;
  logic [WIDTH-1:0] word1   = '0;
  logic [1:0]       grant;
  logic             sr_enable, sr_data, busy, done, done_id;
  logic [1:0]       state_dbg;
`ifdef SRS_ABORT_EN
  logic             abort = 1'b0;
  logic             aborted;
`endif

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  shift_reg_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .word0     (word0),
    .word1     (word1),
`ifdef SRS_ABORT_EN
    .abort     (abort),
    .aborted   (aborted),
`endif
    .grant     (grant),
    .sr_enable (sr_enable),
    .sr_data   (sr_data),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0]       grant;
    logic             en;
    logic             data;
    logic             busy;
    logic             done;
    logic             done_id;
    logic             aborted;
    logic [WIDTH-1:0] word;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur = '0;
  bit   m_last = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [WIDTH-1:0] sr_out = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference model: an accepted job appends its whole WIDTH+1 cycle output timeline.
  always @(posedge clock) begin
    bit               w;
    logic [WIDTH-1:0] wd;
    logic             abort_s;
    exp_t             e;
    cyc++;
    abort_s = 1'b0;
`ifdef SRS_ABORT_EN
    abort_s = abort;
`endif
    if (!reset_n) begin
      exp_q.delete();
      cur    = '0;
      m_last = 1'b1;
    end else if (abort_s && cur.en) begin
      exp_q.delete();
      cur         = '0;
      cur.aborted = 1'b1;
    end else begin
      if (exp_q.size() == 0 && req != 2'b00) begin
        w      = (req == 2'b11) ? !m_last : req[1];
        wd     = w ? word1 : word0;
        m_last = w;
        for (int k = 0; k < WIDTH; k++) begin
          e       = '0;
          e.grant = (k == 0) ? (w ? 2'b10 : 2'b01) : 2'b00;
          e.en    = 1'b1;
          e.data  = wd[k];
          e.busy  = 1'b1;
          exp_q.push_back(e);
        end
        e         = '0;
        e.done    = 1'b1;
        e.done_id = w;
        e.word    = wd;
        exp_q.push_back(e);
      end
      if (exp_q.size() != 0) cur = exp_q.pop_front();
      else cur = '0;
    end
  end

  // Downstream MSB-insertion shift register driven by the DUT.
  always @(posedge clock) begin
    if (!reset_n) sr_out <= '0;
    else if (sr_enable) sr_out <= {sr_data, sr_out[WIDTH-1:1]};
  end

  // Per-cycle compare; done_id only matters while done is expected.
  always @(negedge clock) begin
    logic [7:0] a, x;
    logic       ab;
    if (cyc > 0) begin
      ab = 1'b0;
`ifdef SRS_ABORT_EN
      ab = aborted;
`endif
      a = {grant, sr_enable, sr_data, busy, done, (cur.done ? done_id : 1'b0), ab};
      x = {cur.grant, cur.en, cur.data, cur.busy, cur.done, cur.done_id, cur.aborted};
      check("outputs", 32'(a), 32'(x));
      if (cur.done) check("downstream_out", 32'(sr_out), 32'(cur.word));
    end
  end

  // Passive event log used by the directed scenarios.
  int         g_cyc[$];
  logic [1:0] g_val[$];
  int         d_cyc[$];
  logic       d_id[$];
  int         en_in_done = 0;

  always @(negedge clock) begin
    if (grant != 2'b00) begin
      g_cyc.push_back(cyc);
      g_val.push_back(grant);
    end
    if (done) begin
      d_cyc.push_back(cyc);
      d_id.push_back(done_id);
      if (sr_enable) en_in_done++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_logs();
    g_cyc.delete();
    g_val.delete();
    d_cyc.delete();
    d_id.delete();
    en_in_done = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 2'b00;
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  task automatic wait_grants(input int n);
    for (int i = 0; i < 200 && g_val.size() < n; i++) step();
    if (g_val.size() < n) check("grant_timeout", 32'(g_val.size()), 32'(n));
  endtask

  task automatic wait_dones(input int n);
    for (int i = 0; i < 200 && d_id.size() < n; i++) step();
    if (d_id.size() < n) check("done_timeout", 32'(d_id.size()), 32'(n));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int               act_cnt;
    logic [WIDTH-1:0] bits;

    repeat (3) step();
    reset_n = 1'b1;

    // No requests: nothing may move.
    act_cnt = 0;
    repeat (10) begin
      step();
      if (sr_enable || busy || done || grant != 2'b00) act_cnt++;
    end
    check("idle_quiet", 32'(act_cnt), 32'd0);

    // Single job from requester 0.
    clear_logs();
    req   = 2'b01;
    word0 = 4'b1011;
    wait_grants(1);
    check("s1_grant", 32'(grant), 32'b01);
    req     = 2'b00;
    bits[0] = sr_data;
    for (int k = 1; k < WIDTH; k++) begin
      step();
      bits[k] = sr_data;
    end
    check("s1_serial", 32'(bits), 32'b1011);
    step();
    check("s1_done", 32'({done, done_id}), 32'b10);
    check("s1_out", 32'(sr_out), 32'b1011);

    // Both requesting after reset: 0 then 1, back to back.
    do_reset();
    clear_logs();
    req   = 2'b11;
    word0 = 4'h3;
    word1 = 4'hC;
    wait_grants(1);
    req[0] = 1'b0;
    wait_grants(2);
    req = 2'b00;
    wait_dones(2);
    if (g_val.size() >= 2 && d_id.size() >= 2) begin
      check("s2_grants", 32'({g_val[0], g_val[1]}), 32'b0110);
      check("s2_grant_gap", 32'(g_cyc[1] - g_cyc[0]), 32'd5);
      check("s2_done_ids", 32'({d_id[0], d_id[1]}), 32'b01);
      check("s2_done_gap", 32'(d_cyc[1] - d_cyc[0]), 32'd5);
    end

    // Four jobs with req=11 held.
    do_reset();
    clear_logs();
    req   = 2'b11;
    word0 = WIDTH'($urandom);
    word1 = WIDTH'($urandom);
    wait_grants(4);
    req = 2'b00;
    wait_dones(4);
    if (g_val.size() >= 4)
      check("s3_grant_seq", 32'({g_val[0], g_val[1], g_val[2], g_val[3]}), 32'b01100110);
    check("s3_en_in_done", 32'(en_in_done), 32'd0);

    // Reset in SHIFT cycle 2 abandons the job.
    do_reset();
    clear_logs();
    req   = 2'b01;
    word0 = 4'h9;
    wait_grants(1);
    req = 2'b00;
    step();
    reset_n = 1'b0;
    step();
    check("s4_reset_outs", 32'({grant, sr_enable, sr_data, busy, done, state_dbg}), 32'd0);
    reset_n = 1'b1;
    repeat (8) step();
    check("s4_no_done", 32'(d_id.size()), 32'd0);
    clear_logs();
    req   = 2'b10;
    word1 = 4'h5;
    wait_grants(1);
    req = 2'b00;
    if (g_val.size() >= 1) check("s4_grant1", 32'(g_val[0]), 32'b10);
    wait_dones(1);
    if (d_id.size() >= 1) check("s4_done_id", 32'(d_id[0]), 32'd1);

`ifdef SRS_ABORT_EN
    // Abort in SHIFT cycle 2.
    do_reset();
    clear_logs();
    req   = 2'b01;
    word0 = 4'hA;
    wait_grants(1);
    req = 2'b00;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("s5_aborted", 32'({aborted, sr_enable, busy}), 32'b100);
    repeat (WIDTH + 2) step();
    check("s5_no_done", 32'(d_id.size()), 32'd0);
    clear_logs();
    req   = 2'b01;
    word0 = 4'h6;
    wait_grants(1);
    req = 2'b00;
    wait_dones(1);
    if (d_id.size() >= 1) check("s5_restart_id", 32'(d_id[0]), 32'd0);
`endif

    // Random traffic, including early drops and occasional resets.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (req[i] && grant[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 19) == 0) req[i] = 1'b0;
      end
      word0   = WIDTH'($urandom);
      word1   = WIDTH'($urandom);
      reset_n = ($urandom_range(0, 199) != 0);
`ifdef SRS_ABORT_EN
      abort = ($urandom_range(0, 15) == 0);
`endif
    end
    reset_n = 1'b1;
    req     = 2'b00;
`ifdef SRS_ABORT_EN
    abort = 1'b0;
`endif
    repeat (WIDTH + 4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
